sdram_port_arbiter: RTL and testbench

//  Two-requester Avalon-MM arbiter sharing the single SDRAM controller slave between the DNN

---
 rtl/sdram_port_arbiter_if.sv | 39 +++
 rtl/sdram_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM command/response bundle shared by the arbiter's
// requester ports and its SDRAM controller port.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    output byteenable,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    input  byteenable,
    output waitrequest,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of one SDRAM controller;
// an ID FIFO routes pipelined read data back to its owner.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 8,
  parameter bit PRIORITY    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_port_arbiter_if.slave  s0,
  sdram_port_arbiter_if.slave  s1,
  sdram_port_arbiter_if.master m,
  output logic                 proto_err
);
  localparam int BE_W = DATA_W / 8;
  localparam int PW   = $clog2(MAX_PENDING);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   lock_id_q;
  logic   lock_id_d;
  logic   last_grant_q;

  logic [MAX_PENDING-1:0] id_mem;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW:0]            count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   head_id;

  logic req0;
  logic req1;
  logic gnt_vld;
  logic gnt_id;
  logic cmd_ok;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              sel_rd;
  logic              sel_wr;

  logic m_rd;
  logic m_wr;
  logic accept;
  logic push;
  logic pop;
  logic rdv_ok;

  assign fifo_full  = (count == (PW+1)'(MAX_PENDING));
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rd_ptr];

  assign req0 = s0.write | (s0.read & ~fifo_full);
  assign req1 = s1.write | (s1.read & ~fifo_full);

  // A stalled command keeps its owner until accepted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = last_grant_q;
    if (state_q == ST_LOCKED) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id_q;
    end else begin
      unique case ({req1, req0})
        2'b11: begin
          gnt_vld = 1'b1;
          gnt_id  = PRIORITY ? 1'b1 : ~last_grant_q;
        end
        2'b01: begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end
        2'b10: begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sel_addr  = gnt_id ? s1.address    : s0.address;
  assign sel_wdata = gnt_id ? s1.writedata  : s0.writedata;
  assign sel_be    = gnt_id ? s1.byteenable : s0.byteenable;
  assign sel_rd    = gnt_id ? s1.read       : s0.read;
  assign sel_wr    = gnt_id ? s1.write      : s0.write;

  assign cmd_ok = rst_n & gnt_vld;
  assign m_rd   = cmd_ok & sel_rd;
  assign m_wr   = cmd_ok & sel_wr;
  assign accept = (m_rd | m_wr) & ~m.waitrequest;
  assign push   = accept & m_rd;
  assign rdv_ok = m.readdatavalid & ~fifo_empty;
  assign pop    = rdv_ok;

  assign m.address    = sel_addr;
  assign m.writedata  = sel_wdata;
  assign m.byteenable = sel_be;
  assign m.read       = m_rd;
  assign m.write      = m_wr;

  assign s0.waitrequest = ~(cmd_ok & ~gnt_id) | m.waitrequest;
  assign s1.waitrequest = ~(cmd_ok & gnt_id) | m.waitrequest;

  assign s0.readdata = m.readdata;
  assign s1.readdata = m.readdata;

  assign s0.readdatavalid = rst_n & rdv_ok & ~head_id;
  assign s1.readdatavalid = rst_n & rdv_ok & head_id;

  always_comb begin
    state_d   = ST_OPEN;
    lock_id_d = lock_id_q;
    if ((m_rd | m_wr) & m.waitrequest) begin
      state_d   = ST_LOCKED;
      lock_id_d = gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OPEN;
      lock_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      if (accept) begin
        last_grant_q <= gnt_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= gnt_id;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push & ~pop) begin
        count <= count + (PW+1)'(1);
      end else if (pop & ~push) begin
        count <= count - (PW+1)'(1);
      end
    end
  end

  // Response with nothing outstanding: the data has no owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if (m.readdatavalid & fifo_empty) begin
      proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: round-robin and
// fixed-priority instances share one set of directed stimulus.
module tb_sdram_port_arbiter;
  localparam int AW = 25;
  localparam int DW = 16;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic port;
    cmd_t c;
  } ecmd_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } erd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic          r0_rd = 1'b0, r0_wr = 1'b0;
  logic          r1_rd = 1'b0, r1_wr = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_data = '0, r1_data = '0;
  logic          mw = 1'b0;
  logic          mrdv = 1'b0;
  logic [DW-1:0] mrdata = '0;
  logic          err_a, err_b;

  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) am ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bm ();

  sdram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(8), .PRIORITY(1'b0)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .s0(a0), .s1(a1), .m(am),
    .proto_err(err_a)
  );

  sdram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(8), .PRIORITY(1'b1)
  ) u_fp (
    .clk(clk), .rst_n(rst_n), .s0(b0), .s1(b1), .m(bm),
    .proto_err(err_b)
  );

  assign a0.address = r0_addr;  assign b0.address = r0_addr;
  assign a0.read = r0_rd;       assign b0.read = r0_rd;
  assign a0.write = r0_wr;      assign b0.write = r0_wr;
  assign a0.writedata = r0_data; assign b0.writedata = r0_data;
  assign a0.byteenable = 2'b11; assign b0.byteenable = 2'b11;
  assign a1.address = r1_addr;  assign b1.address = r1_addr;
  assign a1.read = r1_rd;       assign b1.read = r1_rd;
  assign a1.write = r1_wr;      assign b1.write = r1_wr;
  assign a1.writedata = r1_data; assign b1.writedata = r1_data;
  assign a1.byteenable = 2'b11; assign b1.byteenable = 2'b11;
  assign am.waitrequest = mw;   assign bm.waitrequest = mw;
  assign am.readdata = mrdata;  assign bm.readdata = mrdata;
  assign am.readdatavalid = mrdv; assign bm.readdatavalid = mrdv;

  logic          o_s0_wait, o_s1_wait, o_s0_rdv, o_s1_rdv;
  logic [DW-1:0] o_rd0, o_rd1, o_m_wdata;
  logic [AW-1:0] o_m_addr;
  logic [1:0]    o_m_be;
  logic          o_m_rd, o_m_wr, o_err;

  assign o_s0_wait = sel ? b0.waitrequest : a0.waitrequest;
  assign o_s1_wait = sel ? b1.waitrequest : a1.waitrequest;
  assign o_s0_rdv  = sel ? b0.readdatavalid : a0.readdatavalid;
  assign o_s1_rdv  = sel ? b1.readdatavalid : a1.readdatavalid;
  assign o_rd0     = sel ? b0.readdata : a0.readdata;
  assign o_rd1     = sel ? b1.readdata : a1.readdata;
  assign o_m_addr  = sel ? bm.address : am.address;
  assign o_m_wdata = sel ? bm.writedata : am.writedata;
  assign o_m_be    = sel ? bm.byteenable : am.byteenable;
  assign o_m_rd    = sel ? bm.read : am.read;
  assign o_m_wr    = sel ? bm.write : am.write;
  assign o_err     = sel ? err_b : err_a;

  cmd_t  q_req0[$];
  cmd_t  q_req1[$];
  ecmd_t exp_cmd_q[$];
  erd_t  exp_rd_q[$];

  int n_checks = 0;
  int n_fail = 0;
  logic acc0 = 1'b0, acc1 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic req(input bit port, input bit wr, input int addr,
                     input int data);
    cmd_t c;
    c.wr = wr;
    c.addr = AW'(addr);
    c.data = DW'(data);
    if (port) q_req1.push_back(c);
    else q_req0.push_back(c);
  endtask

  task automatic exp_cmd(input bit port, input bit wr, input int addr,
                         input int data);
    ecmd_t e;
    e.port = port;
    e.c.wr = wr;
    e.c.addr = AW'(addr);
    e.c.data = DW'(data);
    exp_cmd_q.push_back(e);
  endtask

  task automatic exp_rd(input bit port, input int data);
    erd_t e;
    e.port = port;
    e.data = DW'(data);
    exp_rd_q.push_back(e);
  endtask

  function automatic bit drained();
    return q_req0.size() == 0 && q_req1.size() == 0 &&
           !(r0_rd | r0_wr | r1_rd | r1_wr) && exp_cmd_q.size() == 0;
  endfunction

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && !drained(); i++) tick(1);
    chk("drain_timeout", 64'(drained()), 64'(1));
  endtask

  task automatic rdv_burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      tick(1);
      mrdv = 1'b1;
      mrdata = DW'(base + i);
    end
    tick(1);
    mrdv = 1'b0;
  endtask

  // Requesters: hold each command until it is accepted.
  initial begin : drv
    cmd_t c;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (!(r0_rd | r0_wr) || acc0) begin
          if (q_req0.size() != 0) begin
            c = q_req0.pop_front();
            r0_rd = !c.wr; r0_wr = c.wr;
            r0_addr = c.addr; r0_data = c.data;
          end else begin
            r0_rd = 1'b0; r0_wr = 1'b0;
          end
        end
        if (!(r1_rd | r1_wr) || acc1) begin
          if (q_req1.size() != 0) begin
            c = q_req1.pop_front();
            r1_rd = !c.wr; r1_wr = c.wr;
            r1_addr = c.addr; r1_data = c.data;
          end else begin
            r1_rd = 1'b0; r1_wr = 1'b0;
          end
        end
      end
    end
  end

  initial begin : mon
    ecmd_t e;
    erd_t  r;
    logic  prev_stall;
    logic [AW+DW+1:0] prev_cmd;
    logic [AW+DW+1:0] cur_cmd;
    prev_stall = 1'b0;
    prev_cmd = '0;
    forever begin
      @(negedge clk);
      acc0 = rst_n & (r0_rd | r0_wr) & ~o_s0_wait;
      acc1 = rst_n & (r1_rd | r1_wr) & ~o_s1_wait;
      cur_cmd = {o_m_rd, o_m_wr, o_m_addr, o_m_wdata};
      if (rst_n) begin
        if (prev_stall) chk("cmd_stable", 64'(cur_cmd), 64'(prev_cmd));
        if ((o_m_rd | o_m_wr) && !mw) begin
          if (exp_cmd_q.size() == 0) begin
            chk("unexpected_accept", 64'(o_m_addr), 64'(0) - 64'(1));
          end else begin
            e = exp_cmd_q.pop_front();
            chk("accept",
                64'({o_s1_wait, o_s0_wait, o_m_wr, o_m_rd, o_m_be,
                     o_m_addr, o_m_wdata}),
                64'({(e.port ? 2'b01 : 2'b10), e.c.wr, ~e.c.wr, 2'b11,
                     e.c.addr, e.c.data}));
          end
        end
        if (o_s0_rdv | o_s1_rdv) begin
          if (exp_rd_q.size() == 0) begin
            chk("unexpected_rdv", 64'({o_s1_rdv, o_s0_rdv}), 64'(0));
          end else begin
            r = exp_rd_q.pop_front();
            chk("readdata",
                64'({o_s1_rdv, o_s0_rdv, o_rd1, o_rd0}),
                64'({(r.port ? 2'b10 : 2'b01), r.data, r.data}));
          end
        end
        prev_stall = (o_m_rd | o_m_wr) & mw;
      end else begin
        prev_stall = 1'b0;
      end
      prev_cmd = cur_cmd;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset: a pending request must not reach the controller.
    r0_rd = 1'b1;
    r0_addr = AW'(32'h10);
    tick(2);
    @(negedge clk);
    chk("rst_s0_wait", 64'(o_s0_wait), 64'(1));
    chk("rst_s1_wait", 64'(o_s1_wait), 64'(1));
    chk("rst_m_cmd", 64'({o_m_rd, o_m_wr}), 64'(0));
    chk("rst_err", 64'(o_err), 64'(0));
    r0_rd = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // 1: single read from s0
    req(0, 0, 'h10, 0);
    exp_cmd(0, 0, 'h10, 0);
    exp_rd(0, 'hA001);
    wait_drain(20);
    rdv_burst(1, 'hA001);

    // 2: round-robin; s0 won last so s1 goes first
    req(0, 0, 'h100, 0); req(0, 0, 'h101, 0);
    req(1, 0, 'h200, 0); req(1, 0, 'h201, 0);
    exp_cmd(1, 0, 'h200, 0); exp_cmd(0, 0, 'h100, 0);
    exp_cmd(1, 0, 'h201, 0); exp_cmd(0, 0, 'h101, 0);
    exp_rd(1, 'hB000); exp_rd(0, 'hB001);
    exp_rd(1, 'hB002); exp_rd(0, 'hB003);
    wait_drain(30);
    rdv_burst(4, 'hB000);

    // 3: stalled write keeps the grant while s1 waits
    tick(1);
    mw = 1'b1;
    req(0, 1, 'h300, 'h5555);
    exp_cmd(0, 1, 'h300, 'h5555);
    tick(1);
    req(1, 0, 'h400, 0);
    exp_cmd(1, 0, 'h400, 0);
    tick(1);
    @(negedge clk);
    chk("lock_s1_wait", 64'(o_s1_wait), 64'(1));
    chk("lock_m_addr", 64'({o_m_wr, o_m_addr}), 64'({1'b1, AW'(32'h300)}));
    tick(1);
    tick(1);
    mw = 1'b0;
    exp_rd(1, 'hC000);
    wait_drain(30);
    rdv_burst(1, 'hC000);

    // 4: eight outstanding reads fill the ID FIFO
    for (int i = 0; i < 9; i++) req(0, 0, 'h500 + i, 0);
    for (int i = 0; i < 8; i++) exp_cmd(0, 0, 'h500 + i, 0);
    for (int i = 0; i < 9; i++) exp_rd(0, 'hD000 + i);
    tick(14);
    @(negedge clk);
    chk("full_s0_wait", 64'(o_s0_wait), 64'(1));
    chk("full_no_read", 64'(o_m_rd), 64'(0));
    req(1, 1, 'h600, 'h1234);
    exp_cmd(1, 1, 'h600, 'h1234);
    exp_cmd(0, 0, 'h508, 0);
    tick(4);
    tick(1);
    mrdv = 1'b1;
    mrdata = DW'(16'hD000);
    @(negedge clk);
    chk("pop_cycle_hold", 64'(o_m_rd), 64'(0));
    tick(1);
    mrdv = 1'b0;
    @(negedge clk);
    chk("read_after_pop", 64'({o_m_rd, o_m_addr}),
        64'({1'b1, AW'(32'h508)}));
    wait_drain(20);
    rdv_burst(8, 'hD001);

    // 6a: response with nothing outstanding
    @(negedge clk);
    chk("err_before", 64'(o_err), 64'(0));
    tick(1);
    mrdv = 1'b1;
    mrdata = DW'(16'hDEAD);
    @(negedge clk);
    chk("orphan_rdv", 64'({o_s1_rdv, o_s0_rdv}), 64'(0));
    tick(1);
    mrdv = 1'b0;
    @(negedge clk);
    chk("err_sticky", 64'(o_err), 64'(1));

    // 6b: reset with reads in flight discards them
    for (int i = 0; i < 3; i++) begin
      req(0, 0, 'h900 + i, 0);
      exp_cmd(0, 0, 'h900 + i, 0);
    end
    wait_drain(20);
    tick(1);
    rst_n = 1'b0;
    mrdv = 1'b1;
    @(negedge clk);
    chk("mid_rst_wait", 64'({o_s1_wait, o_s0_wait}), 64'(3));
    chk("mid_rst_rdv", 64'({o_s1_rdv, o_s0_rdv}), 64'(0));
    chk("mid_rst_err", 64'(o_err), 64'(0));
    tick(2);
    mrdv = 1'b0;
    rst_n = 1'b1;
    tick(2);
    mrdv = 1'b1;
    @(negedge clk);
    chk("post_rst_rdv", 64'({o_s1_rdv, o_s0_rdv}), 64'(0));
    tick(1);
    mrdv = 1'b0;
    @(negedge clk);
    chk("post_rst_err", 64'(o_err), 64'(1));

    // 5: fixed priority instance, s1 starves s0
    tick(1);
    rst_n = 1'b0;
    tick(1);
    sel = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      req(0, 0, 'h700 + i, 0);
      req(1, 0, 'h800 + i, 0);
    end
    for (int i = 0; i < 3; i++) exp_cmd(1, 0, 'h800 + i, 0);
    for (int i = 0; i < 3; i++) exp_cmd(0, 0, 'h700 + i, 0);
    for (int i = 0; i < 3; i++) exp_rd(1, 'hE000 + i);
    for (int i = 0; i < 3; i++) exp_rd(0, 'hE003 + i);
    tick(2);
    @(negedge clk);
    chk("prio_s0_starve", 64'({o_s0_wait, o_m_addr}),
        64'({1'b1, AW'(32'h801)}));
    wait_drain(30);
    rdv_burst(6, 'hE000);

    tick(2);
    chk("rd_leftover", 64'(exp_rd_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
